// File: rtl/sq_freq_meter_if.sv
// Result bundle of the square-wave meter: per-window edge count and per-edge period.
// The meter drives it through the master modport; consumers read it through slave.
interface sq_freq_meter_if #(
    parameter int COUNT_W  = 16,
    parameter int PERIOD_W = 16
);
    logic [COUNT_W-1:0]  meas_count;
    logic                meas_overflow;
    logic                meas_nosig;
    logic                meas_valid;
    logic [PERIOD_W-1:0] period_cycles;
    logic                period_valid;

    modport master (
        output meas_count,
        output meas_overflow,
        output meas_nosig,
        output meas_valid,
        output period_cycles,
        output period_valid
    );

    modport slave (
        input meas_count,
        input meas_overflow,
        input meas_nosig,
        input meas_valid,
        input period_cycles,
        input period_valid
    );
endinterface

// File: rtl/sq_freq_meter.sv
// Measures an asynchronous square wave: rising edges per fixed gate window and
// clk cycles between consecutive rising edges.
//
// Period tracker states:
//   state    | meaning
//   NO_EDGE  | no rising edge seen since reset/enable; nothing to time from
//   TIMING   | counting cycles since the last rising edge
module sq_freq_meter #(
    parameter int GATE_CYCLES = 240000,
    parameter int COUNT_W     = 16,
    parameter int PERIOD_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sq_in,
    sq_freq_meter_if.master  res
);
    localparam int                  GATE_W     = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    localparam logic [0:0] NO_EDGE = 1'b0;
    localparam logic [0:0] TIMING  = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    logic [GATE_W-1:0]      gate_cnt;
    logic                   terminal;

    logic [COUNT_W-1:0]     edge_cnt;
    logic [COUNT_W-1:0]     edge_next;
    logic                   sat_q;
    logic                   sat_next;

    logic [0:0]             state_q;
    logic [PERIOD_W-1:0]    pcnt;

    // Synchronizer keeps running while disabled so a fresh enable sees a settled level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sq_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign terminal = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            gate_cnt <= '0;
        end else if (terminal) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // A rise on the terminal cycle still belongs to the window being closed.
    always_comb begin
        edge_next = edge_cnt;
        if (rise && (edge_cnt != COUNT_MAX)) begin
            edge_next = edge_cnt + 1'b1;
        end
        sat_next = sat_q | (edge_next == COUNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt          <= '0;
            sat_q             <= 1'b0;
            res.meas_count    <= '0;
            res.meas_overflow <= 1'b0;
            res.meas_nosig    <= 1'b0;
            res.meas_valid    <= 1'b0;
        end else if (!en) begin
            edge_cnt       <= '0;
            sat_q          <= 1'b0;
            res.meas_valid <= 1'b0;
        end else if (terminal) begin
            res.meas_count    <= edge_next;
            res.meas_overflow <= sat_next;
            res.meas_nosig    <= (edge_next == '0);
            res.meas_valid    <= 1'b1;
            edge_cnt          <= '0;
            sat_q             <= 1'b0;
        end else begin
            edge_cnt       <= edge_next;
            sat_q          <= sat_next;
            res.meas_valid <= 1'b0;
        end
    end

    // pcnt starts at 1 on a rise so a gap of N clk between rises reports N.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= NO_EDGE;
            pcnt              <= '0;
            res.period_cycles <= '0;
            res.period_valid  <= 1'b0;
        end else if (!en) begin
            state_q          <= NO_EDGE;
            pcnt             <= '0;
            res.period_valid <= 1'b0;
        end else begin
            res.period_valid <= 1'b0;
            case (state_q)
                NO_EDGE: begin
                    if (rise) begin
                        state_q <= TIMING;
                        pcnt    <= PERIOD_W'(1);
                    end
                end
                TIMING: begin
                    if (rise) begin
                        res.period_cycles <= pcnt;
                        res.period_valid  <= 1'b1;
                        pcnt              <= PERIOD_W'(1);
                    end else if (pcnt != PERIOD_MAX) begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sq_freq_meter.sv
// Scoreboard bench for sq_freq_meter: a wide instance (8-bit results) and a narrow
// instance (4-bit results) for saturation, both with a 100-cycle gate.
module tb_sq_freq_meter;
    typedef struct {
        int cnt;
        int ovf;
        int nosig;
    } meas_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic sq_a = 1'b0;
    logic sq_b = 1'b0;

    int total = 0;
    int bad   = 0;

    meas_t mq_a[$];
    meas_t mq_b[$];
    int    pq_a[$];
    int    pq_b[$];

    sq_freq_meter_if #(.COUNT_W(8), .PERIOD_W(8)) ifa ();
    sq_freq_meter_if #(.COUNT_W(4), .PERIOD_W(4)) ifb ();

    sq_freq_meter #(.GATE_CYCLES(100), .COUNT_W(8), .PERIOD_W(8), .SYNC_STAGES(2)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .en    (en_a),
        .sq_in (sq_a),
        .res   (ifa)
    );

    sq_freq_meter #(.GATE_CYCLES(100), .COUNT_W(4), .PERIOD_W(4), .SYNC_STAGES(2)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .en    (en_b),
        .sq_in (sq_b),
        .res   (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: valid pulse with value %0d but none expected", name, act);
    endtask

    task automatic push_meas(input int sel, input int cnt, input int ovf, input int nosig, input int n);
        meas_t m;
        m.cnt = cnt;
        m.ovf = ovf;
        m.nosig = nosig;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) mq_a.push_back(m);
            else          mq_b.push_back(m);
        end
    endtask

    task automatic push_per(input int sel, input int val, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) pq_a.push_back(val);
            else          pq_b.push_back(val);
        end
    endtask

    function automatic logic pat(input int p, input int c);
        case (p)
            10: return (c % 10) < 5;
            20: return (c % 20) < 10;
            6:  return (c >= 7) && (((c - 7) % 10) < 5);
            2: begin
                if (c < 98)       return (c % 2) == 0;
                else if (c < 100) return 1'b0;
                else if (c < 200) return ((c - 100) % 10) < 5;
                else              return ((c - 200) % 40) < 20;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int sel, input int p, input int n);
        for (int c = 0; c < n; c++) begin
            if (sel == 0) begin
                en_a = 1'b1;
                sq_a = pat(p, c);
            end else begin
                en_b = 1'b1;
                sq_b = pat(p, c);
            end
            tick();
        end
    endtask

    task automatic idle(input int n);
        en_a = 1'b0;
        en_b = 1'b0;
        sq_a = 1'b0;
        sq_b = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mon_step();
        meas_t e;
        int    p;
        if (ifa.meas_valid) begin
            if (mq_a.size() == 0) unexpected("a_meas", int'(ifa.meas_count));
            else begin
                e = mq_a.pop_front();
                chk("a_meas_count", int'(ifa.meas_count), e.cnt);
                chk("a_meas_overflow", int'(ifa.meas_overflow), e.ovf);
                chk("a_meas_nosig", int'(ifa.meas_nosig), e.nosig);
            end
        end
        if (ifa.period_valid) begin
            if (pq_a.size() == 0) unexpected("a_period", int'(ifa.period_cycles));
            else begin
                p = pq_a.pop_front();
                chk("a_period_cycles", int'(ifa.period_cycles), p);
            end
        end
        if (ifb.meas_valid) begin
            if (mq_b.size() == 0) unexpected("b_meas", int'(ifb.meas_count));
            else begin
                e = mq_b.pop_front();
                chk("b_meas_count", int'(ifb.meas_count), e.cnt);
                chk("b_meas_overflow", int'(ifb.meas_overflow), e.ovf);
                chk("b_meas_nosig", int'(ifb.meas_nosig), e.nosig);
            end
        end
        if (ifb.period_valid) begin
            if (pq_b.size() == 0) unexpected("b_period", int'(ifb.period_cycles));
            else begin
                p = pq_b.pop_front();
                chk("b_period_cycles", int'(ifb.period_cycles), p);
            end
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_meas_count"}, int'(ifa.meas_count), 0);
        chk({tag, "_meas_overflow"}, int'(ifa.meas_overflow), 0);
        chk({tag, "_meas_nosig"}, int'(ifa.meas_nosig), 0);
        chk({tag, "_meas_valid"}, int'(ifa.meas_valid), 0);
        chk({tag, "_period_cycles"}, int'(ifa.period_cycles), 0);
        chk({tag, "_period_valid"}, int'(ifa.period_valid), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        rst = 1'b1;
        tick();
        tick();
        tick();
        chk_zero_a("rst");
        chk("rst_b_meas_count", int'(ifb.meas_count), 0);
        rst = 1'b0;
        idle(3);

        // steady 10-cycle square wave over three windows
        push_meas(0, 10, 0, 0, 3);
        push_per(0, 10, 29);
        run(0, 10, 300);
        idle(5);

        // enable dropped mid-window: partial window discarded, outputs held
        push_per(0, 10, 5);
        run(0, 10, 60);
        idle(20);
        chk("hold_meas_count", int'(ifa.meas_count), 10);
        chk("hold_meas_overflow", int'(ifa.meas_overflow), 0);
        chk("hold_meas_nosig", int'(ifa.meas_nosig), 0);
        chk("hold_period_cycles", int'(ifa.period_cycles), 10);
        push_meas(0, 5, 0, 0, 1);
        push_per(0, 20, 4);
        run(0, 20, 100);
        idle(5);

        // no signal
        push_meas(0, 0, 0, 1, 2);
        run(0, 0, 200);
        idle(5);
        chk("nosig_held", int'(ifa.meas_nosig), 1);
        chk("nosig_period_held", int'(ifa.period_cycles), 20);

        // rises land on the terminal cycle of each window
        push_meas(0, 10, 0, 0, 2);
        push_per(0, 10, 19);
        run(0, 6, 200);
        idle(5);

        // reset in the middle of a window
        push_per(0, 10, 4);
        run(0, 10, 50);
        rst  = 1'b1;
        en_a = 1'b1;
        sq_a = 1'b0;
        tick();
        chk_zero_a("midrst");
        rst = 1'b0;
        push_meas(0, 10, 0, 0, 1);
        push_per(0, 10, 9);
        run(0, 10, 100);
        idle(5);

        // narrow instance: edge-count and period saturation, then recovery
        push_meas(1, 15, 1, 0, 1);
        push_meas(1, 10, 0, 0, 1);
        push_meas(1, 3, 0, 0, 1);
        push_per(1, 2, 48);
        push_per(1, 4, 1);
        push_per(1, 10, 10);
        push_per(1, 15, 2);
        run(1, 2, 300);
        idle(5);

        chk("a_meas_left", mq_a.size(), 0);
        chk("a_period_left", pq_a.size(), 0);
        chk("b_meas_left", mq_b.size(), 0);
        chk("b_period_left", pq_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
